// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   WORD_BYTES        : PC increment per fetched instruction
//   fetch_state_e     : RUN / HALT sequencer state
//   DEFAULT_RESET_PC  : default reset byte address
//   DEFAULT_PC_LIMIT  : default first byte address past the program
//   q_entry_t         : one queue entry {pc, instr}
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_LIMIT = 32'd64;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } q_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Two-entry synchronous FIFO holding fetched {pc, instr} pairs. Slot 0 is
// always the head, so the head outputs come straight from flops.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   push_i, din_i    : write din_i to the tail
//   pop_i            : head leaves at the clock edge
//   flush_i          : discard all entries (wins over push/pop)
//   count_o          : number of valid entries (0..2)
//   valid_o, head_o  : head entry and its valid flag
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  q_entry_t   din_i,
    output logic [1:0] count_o,
    output logic       valid_o,
    output q_entry_t   head_o
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    q_entry_t   slot_q [DEPTH];
    q_entry_t   slot_d [DEPTH];
    logic [1:0] count_q;
    logic [1:0] count_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
        end
        count_d = count_q;

        if (flush_i) begin
            // Storage is left untouched so the head outputs hold their value.
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    slot_d[count_q[0]] = din_i;
                    count_d            = count_q + 2'd1;
                end
                2'b01: begin
                    // Only shift when a second entry exists; otherwise the
                    // head keeps its last value while the queue is empty.
                    if (count_q == FULL) begin
                        slot_d[0] = slot_q[1];
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == FULL) begin
                        slot_d[0] = slot_q[1];
                        slot_d[1] = din_i;
                    end else begin
                        slot_d[0] = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= 2'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign head_o  = slot_q[0];

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch sequencer: owns the PC, addresses a combinational
// instruction memory, buffers fetched words in a 2-entry queue and hands them
// to decode over valid/ready. Redirects flush the queue and reload the PC;
// fetch halts once the PC reaches PC_LIMIT.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   imem_addr / imem_instr       : word address out, instruction word in
//   redirect_valid, redirect_pc  : taken branch/jump and its byte target
//   out_valid/out_ready          : decode handshake
//   out_instr, out_pc            : head instruction and its byte PC
//   halted                       : fetch stopped at PC_LIMIT
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_LIMIT  = DEFAULT_PC_LIMIT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    q_entry_t     head;
    q_entry_t     din;

    // Target alignment bits are forced to zero, so they are never read.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign pop = out_valid && out_ready;
    assign din = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;

        if (redirect_valid) begin
            // Redirect restarts fetch; a target past the limit is caught on
            // the following cycle by the RUN branch below.
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (pc_q >= PC_LIMIT) begin
                state_d = HALT;
            end else if ((count < FULL) || pop) begin
                push = 1'b1;
                pc_d = pc_q + WORD_BYTES;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH(BUF_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   (din),
        .count_o (count),
        .valid_o (out_valid),
        .head_o  (head)
    );

    assign imem_addr = {2'b00, pc_q[31:2]};
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with a 16-word combinational program memory.
// "Cycle k" is the state observed #1 after the k-th rising edge following
// reset release; cycle 0 shows reset values.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd16) ? mem[imem_addr[3:0]] : 32'h0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("chk  %s: got %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release it; returns at cycle 0.
    task automatic do_reset(input logic ready);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = ready;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'hA000_0000 | 32'(i);
        end
        mem[0] = 32'h0022_1820;
        mem[1] = 32'h2109_000A;
        mem[9] = 32'h0800_0000;

        // ---- A: reset values, then one instruction per cycle
        do_reset(1'b1);
        check_val("A rst out_valid", 32'(out_valid), 32'd0);
        check_val("A rst out_pc",    out_pc,         32'h0);
        check_val("A rst out_instr", out_instr,      32'h0);
        check_val("A rst halted",    32'(halted),    32'd0);
        check_val("A rst imem_addr", imem_addr,      32'h0);
        step();
        check_val("A c1 out_valid",  32'(out_valid), 32'd1);
        check_val("A c1 out_pc",     out_pc,         32'h0);
        check_val("A c1 out_instr",  out_instr,      32'h0022_1820);
        step();
        check_val("A c2 out_pc",     out_pc,         32'h4);
        check_val("A c2 out_instr",  out_instr,      32'h2109_000A);
        step();
        check_val("A c3 out_pc",     out_pc,         32'h8);

        // ---- B: backpressure saturates the queue at two entries
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step();
        check_val("B full imem_addr", imem_addr,      32'd2);
        check_val("B full out_valid", 32'(out_valid), 32'd1);
        check_val("B full out_pc",    out_pc,         32'h0);
        out_ready = 1'b1;
        step();
        check_val("B rel out_pc 4",   out_pc,         32'h4);
        step();
        check_val("B rel out_pc 8",   out_pc,         32'h8);

        // ---- C: redirect to 0x24 with a full queue at cycle 3
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h24;
        step();
        redirect_valid = 1'b0;
        check_val("C c4 out_valid",  32'(out_valid), 32'd0);
        check_val("C c4 imem_addr",  imem_addr,      32'd9);
        step();
        check_val("C c5 out_valid",  32'(out_valid), 32'd1);
        check_val("C c5 out_pc",     out_pc,         32'h24);
        check_val("C c5 out_instr",  out_instr,      32'h0800_0000);

        // ---- D: free run to the limit, halt, drain, redirect back to 0
        do_reset(1'b1);
        for (int k = 1; k <= 16; k++) begin
            step();
            check_val($sformatf("D c%0d out_pc", k), out_pc, 32'(4 * (k - 1)));
        end
        check_val("D c16 halted",    32'(halted),    32'd0);
        check_val("D c16 imem_addr", imem_addr,      32'd16);
        step();
        check_val("D c17 halted",    32'(halted),    32'd1);
        check_val("D c17 out_valid", 32'(out_valid), 32'd0);
        step();
        check_val("D c18 imem_addr", imem_addr,      32'd16);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check_val("D c19 halted",    32'(halted),    32'd0);
        check_val("D c19 out_valid", 32'(out_valid), 32'd0);
        step();
        check_val("D c20 out_valid", 32'(out_valid), 32'd1);
        check_val("D c20 out_pc",    out_pc,         32'h0);

        // ---- E: misaligned redirect, then redirect past the limit
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        step();
        redirect_valid = 1'b0;
        step();
        check_val("E mis out_pc",    out_pc,         32'h10);
        check_val("E mis out_instr", out_instr,      32'hA000_0004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        check_val("E far+1 halted",    32'(halted), 32'd0);
        check_val("E far+1 imem_addr", imem_addr,   32'h20);
        step();
        check_val("E far+2 halted",    32'(halted),    32'd1);
        check_val("E far+2 out_valid", 32'(out_valid), 32'd0);

        // ---- F: reset plus redirect mid-stream with a full queue
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h24;
        step();
        check_val("F rst out_valid", 32'(out_valid), 32'd0);
        check_val("F rst halted",    32'(halted),    32'd0);
        check_val("F rst imem_addr", imem_addr,      32'h0);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        step();
        check_val("F c1 out_pc",    out_pc,         32'h0);
        check_val("F c1 out_valid", 32'(out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch sequencer for the 32-bit MIPS core. It owns the program counter and drives the combinational instruction memory's word address. It buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake. It also applies branch/jump redirects with flush and halts when the PC leaves the populated program region.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
PC_LIMIT, 32'd64, first byte address past the program (16 words); fetch at or beyond it halts
BUF_DEPTH, 2, instruction queue entries; fixed at 2, other values unsupported

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  32  word index to instruction memory = {2'b00, pc[31:2]}
imem_instr  in  32  instruction word returned combinationally for imem_addr
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  byte target of redirect; bits [1:0] ignored (forced 0)
out_valid  out  1  queue head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  instruction at queue head
out_pc  out  32  byte PC of out_instr
halted  out  1  fetch stopped at PC_LIMIT

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=RUN, queue count=0, out_valid=0, out_instr=0, out_pc=0, halted=0.
  - Reset asserted mid-operation discards the queue and any redirect in the same cycle.
- States:
  - RUN: fetch each cycle when permitted.
  - HALT: no fetch; pc holds; halted=1.
- Pop: a pop occurs when out_valid && out_ready. The head entry leaves at the clock edge.
- Push condition (RUN only): no redirect_valid, pc < PC_LIMIT, and (count < 2 or pop this cycle).
  - A push writes {pc, imem_instr} to the tail and sets pc <= pc + 4.
- Full queue (count==2) without pop: no push, pc holds. Push and pop in the same cycle at count 2 are legal; count stays 2.
- Empty queue: out_valid=0; out_instr/out_pc hold their last values (don't-care).
- Latency: an instruction fetched at cycle N appears at the head with out_valid=1 in cycle N+1. The first instruction is visible one cycle after reset deasserts.
- Ordering: strict FIFO; out_pc values are monotonically +4 between redirects.
- Redirect (priority over everything except reset):
  - Flushes the queue (count <= 0).
  - Sets pc <= {redirect_pc[31:2], 2'b00}.
  - Performs no push that cycle.
  - Forces state=RUN and halted=0.
  - A pop coinciding with a redirect still counts as consumed by decode.
  - The first post-redirect instruction appears 2 cycles after the redirect cycle.
- RUN with pc >= PC_LIMIT and no redirect: go to HALT next cycle, no push. Queued entries still drain normally.
- Redirect to a target >= PC_LIMIT: next cycle RUN with no push, then HALT.
- PC arithmetic: 32-bit unsigned, wraps modulo 2^32; wrap cannot occur below PC_LIMIT.
- All outputs except imem_addr are registered; imem_addr is combinational from the pc register.

Decomposition:
- Shared package fetch_pkg:
  - WORD_BYTES=4
  - state encoding (RUN=1'b0, HALT=1'b1)
  - default RESET_PC/PC_LIMIT constants
  - queue-entry struct {pc[31:0], instr[31:0]}
- One natural sub-module: fetch_queue, a 2-entry synchronous FIFO with push, pop, flush, count, and head outputs. The PC/state logic stays in fetch_unit.

Test Plan:
- Reset release, out_ready=1, memory preloaded: cycle 1 out_valid=1, out_pc=0, out_instr=32'h00221820; cycle 2 out_pc=4, out_instr=32'h2109000A; one instruction per cycle thereafter.
- out_ready=0 for 5 cycles after reset: count saturates at 2, imem_addr holds at 2 (pc=8). On release, out_pc sequence is 0, 4, 8 with no gaps or duplicates.
- Redirect at cycle 3 with redirect_pc=32'h24 while queue is full: queue flushed, out_valid=0 in cycle 4, cycle 5 out_pc=32'h24 (word 9, J instruction).
- Free-running with out_ready=1: after out_pc=60 is pushed, pc=64 and halted=1 two cycles later; no push with pc>=64; queue drains. A redirect to 32'h0 clears halted and resumes fetching from out_pc=0.
- Redirect to 32'h13 (misaligned): fetch resumes at out_pc=32'h10. Redirect to 32'h80: no push, halted=1 two cycles later.
- Reset asserted mid-stream with count=2 and redirect_valid=1 in the same cycle: next cycle out_valid=0, halted=0, imem_addr=0, and the redirect is ignored.
